// File: rtl/pulse_cond_pkg.sv
// pulse_cond_pkg: shared state encodings, counter widths and limits for the pulse conditioner.
package pulse_cond_pkg;
    localparam int FLT_W  = 8;
    localparam int HOLD_W = 16;
    localparam int TMO_W  = 24;
    localparam logic [15:0] GLITCH_MAX = 16'hFFFF;
    localparam logic [1:0] ST_LOW_STABLE  = 2'd0;
    localparam logic [1:0] ST_RISE_QUAL   = 2'd1;
    localparam logic [1:0] ST_HIGH_STABLE = 2'd2;
    localparam logic [1:0] ST_FALL_QUAL   = 2'd3;
    typedef enum logic [1:0] {
        LOW_STABLE  = ST_LOW_STABLE,
        RISE_QUAL   = ST_RISE_QUAL,
        HIGH_STABLE = ST_HIGH_STABLE,
        FALL_QUAL   = ST_FALL_QUAL
    } state_e;
    function automatic logic level_of(input state_e st);
        return (st == HIGH_STABLE) || (st == FALL_QUAL);
    endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: parameterised-depth flop chain bringing an asynchronous input into the clk domain.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] ff_q, ff_d;
    always_comb ff_d = {ff_q[DEPTH-2:0], d};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= '0;
        else        ff_q <= ff_d;
    end
    assign q = ff_q[DEPTH-1];
endmodule

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronise, qualify and stretch a raw pulse; report glitches and loss of signal.
module pulse_conditioner
    import pulse_cond_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [FLT_W-1:0]  FILTER_LEN  = 8'd8,
    parameter logic [HOLD_W-1:0] MIN_HOLD    = 16'd22,
    parameter logic [TMO_W-1:0]  TIMEOUT     = 24'd1000000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        pulse_in,
    input  logic        enable,
    input  logic        clr_stats,
    output logic        pulse_out,
    output logic        rise_strobe,
    output logic        fall_strobe,
    output logic [15:0] glitch_count,
    output logic        no_signal
);
    state_e              state_q, state_d;
    logic [FLT_W-1:0]    flt_q, flt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         glitch_q, glitch_d;
    logic                pulse_out_q, pulse_out_d;
    logic                rise_q, rise_d, fall_q, fall_d;
    logic                s, glitch_inc;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk   (CLK),
        .rst_n (rst_n),
        .d     (pulse_in),
        .q     (s)
    );

    always_comb begin
        state_d    = state_q;
        flt_d      = flt_q;
        hold_d     = hold_q;
        tmo_d      = (tmo_q == TIMEOUT) ? tmo_q : tmo_q + TMO_W'(1);
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_inc = 1'b0;
        if (!enable) begin
            state_d = LOW_STABLE;
            flt_d   = '0;
            hold_d  = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                LOW_STABLE, HIGH_STABLE: begin
                    // Stable states: a running hold masks the input entirely.
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else if (s != level_of(state_q)) begin
                        state_d = (state_q == LOW_STABLE) ? RISE_QUAL : FALL_QUAL;
                        flt_d   = FLT_W'(1);
                    end
                end
                RISE_QUAL, FALL_QUAL: begin
                    if (s == level_of(state_q)) begin
                        state_d    = (state_q == RISE_QUAL) ? LOW_STABLE : HIGH_STABLE;
                        glitch_inc = 1'b1;
                    end else if (flt_q == FILTER_LEN) begin
                        state_d = (state_q == RISE_QUAL) ? HIGH_STABLE : LOW_STABLE;
                        rise_d  = (state_q == RISE_QUAL);
                        fall_d  = (state_q == FALL_QUAL);
                        hold_d  = MIN_HOLD;
                        tmo_d   = '0;
                    end else begin
                        flt_d = flt_q + FLT_W'(1);
                    end
                end
                default: state_d = LOW_STABLE;
            endcase
        end
        glitch_d    = clr_stats ? '0 :
                      (glitch_inc && glitch_q != GLITCH_MAX) ? glitch_q + 16'd1 : glitch_q;
        pulse_out_d = level_of(state_d);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOW_STABLE;
            flt_q       <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            glitch_q    <= '0;
            pulse_out_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flt_q       <= flt_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            glitch_q    <= glitch_d;
            pulse_out_q <= pulse_out_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign pulse_out    = pulse_out_q;
    assign rise_strobe  = rise_q;
    assign fall_strobe  = fall_q;
    assign glitch_count = glitch_q;
    assign no_signal    = (tmo_q == TIMEOUT);
endmodule

// File: tb/tb_pulse_conditioner.sv
// tb_pulse_conditioner: directed stimulus checked every cycle against a run-length model plus literal expectations.
module tb_pulse_conditioner;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int HOLD = 22;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst_n, pulse_in, enable, clr_stats;
    logic        pulse_out, rise_strobe, fall_strobe, no_signal;
    logic [15:0] glitch_count;

    int n_chk = 0;
    int n_pass = 0;
    bit preset = 1'b0;

    pulse_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (8'd4),
        .MIN_HOLD    (16'd22),
        .TIMEOUT     (24'd1000)
    ) dut (
        .CLK          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .enable       (enable),
        .clr_stats    (clr_stats),
        .pulse_out    (pulse_out),
        .rise_strobe  (rise_strobe),
        .fall_strobe  (fall_strobe),
        .glitch_count (glitch_count),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    // Model: a level change is accepted after FILTER_LEN+1 consecutive differing
    // samples taken once the hold has run out; a shorter run is a glitch.
    bit [SYNC-1:0] sh;
    bit            m_out, m_rise, m_fall, m_s, m_inc;
    int            m_run, m_hold, m_tmo;
    logic [15:0]   m_glitch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh = '0; m_out = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_hold = 0; m_tmo = 0; m_glitch = 16'd0;
        end else begin
            m_s = sh[SYNC-1];
            sh = {sh[SYNC-2:0], pulse_in};
            m_rise = 0; m_fall = 0; m_inc = 0;
            if (!enable) begin
                m_out = 0; m_run = 0; m_hold = 0; m_tmo = 0;
            end else begin
                if (m_tmo < TMO) m_tmo++;
                if (m_hold > 0) begin
                    m_hold--;
                    m_run = 0;
                end else if (m_s != m_out) begin
                    m_run++;
                    if (m_run == FILT + 1) begin
                        m_out = m_s; m_rise = m_s; m_fall = !m_s;
                        m_hold = HOLD; m_run = 0; m_tmo = 0;
                    end
                end else begin
                    m_inc = (m_run > 0);
                    m_run = 0;
                end
            end
            if (clr_stats) m_glitch = 16'd0;
            else if (m_inc && m_glitch != 16'hFFFF) m_glitch = m_glitch + 16'd1;
            if (preset) m_glitch = 16'hFFFE;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("model", {12'd0, pulse_out, rise_strobe, fall_strobe, no_signal, glitch_count},
                {12'd0, m_out, m_rise, m_fall, (m_tmo == TMO), m_glitch});
        end
    endtask

    task automatic wait_strobe(input bit fall, input int bound, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (((fall ? fall_strobe : rise_strobe) == 1'b0) && n < bound);
    endtask

    task automatic spike(output int strobes);
        strobes = 0;
        pulse_in = 1'b1;
        repeat (3) begin tick(1); strobes += rise_strobe + fall_strobe; end
        pulse_in = 1'b0;
        repeat (20) begin tick(1); strobes += rise_strobe + fall_strobe; end
    endtask

    initial begin
        int n, rises, falls, st;
        rst_n = 1'b0; pulse_in = 1'b0; enable = 1'b1; clr_stats = 1'b0;
        tick(3);
        chk("rst_pulse_out", pulse_out, 0);
        chk("rst_glitch", glitch_count, 0);
        chk("rst_no_signal", no_signal, 0);
        rst_n = 1'b1;

        tick(999);
        chk("nosig_999", no_signal, 0);
        tick(1);
        chk("nosig_1000", no_signal, 1);

        pulse_in = 1'b1;
        wait_strobe(0, 40, n);
        chk("rise_latency", n, 7);
        chk("nosig_at_rise", no_signal, 0);
        chk("out_at_rise", pulse_out, 1);
        tick(100 - n);
        pulse_in = 1'b0;
        wait_strobe(1, 40, n);
        chk("fall_latency", n, 7);
        tick(100 - n);
        rises = 0; falls = 0;
        pulse_in = 1'b1;
        repeat (100) begin tick(1); rises += rise_strobe; falls += fall_strobe; end
        pulse_in = 1'b0;
        repeat (100) begin tick(1); rises += rise_strobe; falls += fall_strobe; end
        chk("period_rises", rises, 1);
        chk("period_falls", falls, 1);
        chk("square_glitch", glitch_count, 0);

        spike(st);
        chk("spike_strobes", st, 0);
        chk("spike_out", pulse_out, 0);
        chk("spike_glitch", glitch_count, 1);

        tick(30);
        pulse_in = 1'b1;
        wait_strobe(0, 40, n);
        chk("hold_rise_latency", n, 7);
        tick(5);
        pulse_in = 1'b0;
        wait_strobe(1, 60, n);
        chk("hold_fall_delay", n, 22);
        chk("hold_glitch", glitch_count, 1);
        tick(40);

        force dut.glitch_q = 16'hFFFE;
        preset = 1'b1;
        tick(1);
        release dut.glitch_q;
        preset = 1'b0;
        spike(st);
        chk("sat_reach", glitch_count, 16'hFFFF);
        spike(st);
        chk("sat_hold", glitch_count, 16'hFFFF);
        pulse_in = 1'b1;
        tick(3);
        pulse_in = 1'b0;
        tick(2);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        chk("clr_vs_glitch", glitch_count, 0);
        tick(20);

        spike(st);
        pulse_in = 1'b1;
        wait_strobe(0, 40, n);
        tick(3);
        enable = 1'b0;
        tick(1);
        chk("en_off_out", pulse_out, 0);
        chk("en_off_nosig", no_signal, 0);
        st = fall_strobe;
        repeat (5) begin tick(1); st += rise_strobe + fall_strobe; end
        chk("en_off_strobes", st, 0);
        chk("en_off_glitch", glitch_count, 1);
        enable = 1'b1;
        wait_strobe(0, 40, n);
        chk("en_rerise_latency", n, 5);
        chk("en_glitch_kept", glitch_count, 1);

        pulse_in = 1'b0;
        wait_strobe(1, 60, n);
        tick(30);
        pulse_in = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("rst_async_glitch", glitch_count, 0);
        chk("rst_async_out_qual", pulse_out, 0);
        tick(2);
        rst_n = 1'b1;
        wait_strobe(0, 40, n);
        chk("post_rst_rise", n, 7);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_high", pulse_out, 0);
        chk("rst_async_no_fall", fall_strobe, 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
